// File: rtl/iommu_wsi_gateway.sv
// rtl/iommu_wsi_gateway.sv - IOMMU wire-signaled interrupt gateway with claim/complete handshake
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wsi_wires_i[N_SRC]    level-sensitive WSI wires from the IOMMU
//   enable_i[N_SRC]       per-source enable (gates irq and arbitration, not capture)
//   claim_req_i           single-cycle claim strobe
//   claim_valid_o         one-cycle claim response pulse
//   claim_id_o            claimed ID (source index + 1, 0 = nothing pending), held between claims
//   complete_req_i        completion strobe
//   complete_id_i         ID being completed
//   pending_o[N_SRC]      per-source PENDING state
//   irq_o                 interrupt request to the hart
//
// Build option: define IOMMU_WSI_SYNC_EN to add a 2-flop synchronizer on each wire
// (wire->pending latency becomes 3 cycles instead of 1).

module iommu_wsi_gateway #(
    parameter int N_SRC = 16,
    parameter int ID_W  = $clog2(N_SRC) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] wsi_wires_i,
    input  logic [N_SRC-1:0] enable_i,
    input  logic             claim_req_i,
    output logic             claim_valid_o,
    output logic [ID_W-1:0]  claim_id_o,
    input  logic             complete_req_i,
    input  logic [ID_W-1:0]  complete_id_i,
    output logic [N_SRC-1:0] pending_o,
    output logic             irq_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_PENDING    = 2'b01,
        S_IN_SERVICE = 2'b10
    } src_state_t;

    src_state_t        state_q [N_SRC];
    src_state_t        state_d [N_SRC];
    logic [N_SRC-1:0]  wires_s;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  pend_next;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;

`ifdef IOMMU_WSI_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= wsi_wires_i;
            sync2_q <= sync1_q;
        end
    end

    assign wires_s = sync2_q;
`else
    // Wires are assumed synchronous to clk_i in this build.
    assign wires_s = wsi_wires_i;
`endif

    // Arbitration uses only the pre-edge state, so a source that becomes
    // PENDING (or leaves IN_SERVICE) at this edge cannot win this claim.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = (state_q[i] == S_PENDING) && enable_i[i];
        end
    end

    // Scan high to low so the lowest eligible index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (wires_s[i]) begin
                        state_d[i] = S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (claim_req_i && sel_found && (sel_idx == ID_W'(i))) begin
                        state_d[i] = S_IN_SERVICE;
                    end
                end
                S_IN_SERVICE: begin
                    // Only an exact ID match completes; ID 0 and out-of-range IDs
                    // never match any source index + 1.
                    if (complete_req_i && (complete_id_i == ID_W'(i + 1))) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
            pend_next[i] = (state_d[i] == S_PENDING);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= S_IDLE;
            end
            pending_o     <= '0;
            irq_o         <= 1'b0;
            claim_valid_o <= 1'b0;
            claim_id_o    <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= state_d[i];
            end
            pending_o     <= pend_next;
            irq_o         <= |(pend_next & enable_i);
            claim_valid_o <= claim_req_i;
            if (claim_req_i) begin
                claim_id_o <= sel_found ? (sel_idx + ID_W'(1)) : '0;
            end
        end
    end

endmodule

// File: tb/tb_iommu_wsi_gateway.sv
// tb/tb_iommu_wsi_gateway.sv - directed self-checking bench for iommu_wsi_gateway

module tb_iommu_wsi_gateway;

    localparam int N_SRC = 16;
    localparam int ID_W  = 5;
`ifdef IOMMU_WSI_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk;
    logic             rst_i;
    logic [N_SRC-1:0] wsi_wires_i;
    logic [N_SRC-1:0] enable_i;
    logic             claim_req_i;
    logic             claim_valid_o;
    logic [ID_W-1:0]  claim_id_o;
    logic             complete_req_i;
    logic [ID_W-1:0]  complete_id_i;
    logic [N_SRC-1:0] pending_o;
    logic             irq_o;

    int total = 0;
    int bad   = 0;
    logic [ID_W-1:0] exp_q [$];

    iommu_wsi_gateway #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wsi_wires_i    (wsi_wires_i),
        .enable_i       (enable_i),
        .claim_req_i    (claim_req_i),
        .claim_valid_o  (claim_valid_o),
        .claim_id_o     (claim_id_o),
        .complete_req_i (complete_req_i),
        .complete_id_i  (complete_id_i),
        .pending_o      (pending_o),
        .irq_o          (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        wsi_wires_i = '0;
        claim_req_i = 1'b0;
        complete_req_i = 1'b0;
        step(2);
        rst_i = 1'b0;
    endtask

    task automatic claim(input logic [ID_W-1:0] exp_id);
        exp_q.push_back(exp_id);
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
    endtask

    task automatic complete(input logic [ID_W-1:0] id);
        complete_req_i = 1'b1;
        complete_id_i  = id;
        step();
        complete_req_i = 1'b0;
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding claim.
    always @(negedge clk) begin
        if (claim_valid_o === 1'b1) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL claim_spurious observed_id=%0d expected=no_pulse", claim_id_o);
            end
            if (exp_q.size() > 0) begin
                chk("claim_id", 32'(claim_id_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_i          = 1'b1;
        wsi_wires_i    = '0;
        enable_i       = 16'hFFFF;
        claim_req_i    = 1'b0;
        complete_req_i = 1'b0;
        complete_id_i  = '0;
        step(2);
        chk("rst_pending", 32'(pending_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_claim_valid", 32'(claim_valid_o), 32'h0);
        chk("rst_claim_id", 32'(claim_id_o), 32'h0);

        // Reset landing on a claim edge aborts it: no response pulse.
        rst_i       = 1'b0;
        wsi_wires_i = 16'hFFFF;
        step(LAT);
        chk("all_pending", 32'(pending_o), 32'hFFFF);
        claim_req_i = 1'b1;
        rst_i       = 1'b1;
        step();
        claim_req_i = 1'b0;
        chk("midclaim_rst_pending", 32'(pending_o), 32'h0);
        chk("midclaim_rst_irq", 32'(irq_o), 32'h0);
        chk("midclaim_rst_valid", 32'(claim_valid_o), 32'h0);
        rst_i = 1'b0;
        step(LAT);
        chk("capture_resumes", 32'(pending_o), 32'hFFFF);

        // Priority between sources 3 and 9.
        do_reset();
        wsi_wires_i = 16'h0208;
        step(LAT);
        chk("prio_pending", 32'(pending_o), 32'h0208);
        chk("prio_irq", 32'(irq_o), 32'h1);
        wsi_wires_i = '0;
        claim(5'd4);
        chk("prio_after1", 32'(pending_o), 32'h0200);
        claim(5'd10);
        chk("prio_after2", 32'(pending_o), 32'h0);
        chk("prio_irq_low", 32'(irq_o), 32'h0);

        // Masking: source 5 captured but disabled.
        do_reset();
        chk("rst_clears_claim_id", 32'(claim_id_o), 32'h0);
        enable_i    = 16'hFFDF;
        wsi_wires_i = 16'h0020;
        step(LAT);
        chk("mask_pending", 32'(pending_o), 32'h0020);
        chk("mask_irq", 32'(irq_o), 32'h0);
        claim(5'd0);
        chk("mask_still_pending", 32'(pending_o), 32'h0020);
        chk("claim_id_held", 32'(claim_id_o), 32'h0);
        enable_i = 16'hFFFF;
        step();
        chk("unmask_irq", 32'(irq_o), 32'h1);
        wsi_wires_i = '0;
        claim(5'd6);
        chk("unmask_claimed", 32'(pending_o), 32'h0);

        // Level re-pend after completion while the wire stays high.
        do_reset();
        wsi_wires_i = 16'h0001;
        step(LAT);
        chk("lvl_pending", 32'(pending_o), 32'h0001);
        claim(5'd1);
        chk("lvl_in_service", 32'(pending_o), 32'h0);
        step(2);
        chk("lvl_ignored_in_service", 32'(pending_o), 32'h0);
        complete(5'd1);
        step();
        chk("lvl_repend", 32'(pending_o), 32'h0001);
        claim(5'd1);
        wsi_wires_i = '0;
        step(LAT + 1);
        complete(5'd1);
        step(2);
        chk("lvl_no_repend", 32'(pending_o), 32'h0);

        // Illegal completes: source 0 in service (wire held), source 2 pending.
        do_reset();
        wsi_wires_i = 16'h0005;
        step(LAT);
        chk("ill_pending", 32'(pending_o), 32'h0005);
        claim(5'd1);
        complete(5'd0);
        complete(5'd17);
        complete(5'd3);
        step(2);
        chk("ill_no_change", 32'(pending_o), 32'h0004);
        claim(5'd3);
        chk("ill_claim_src2", 32'(pending_o), 32'h0);
        claim(5'd0);

        // Same-cycle claim + complete.
        do_reset();
        wsi_wires_i = 16'h0012;
        step(LAT);
        chk("cc_pending", 32'(pending_o), 32'h0012);
        claim(5'd2);
        wsi_wires_i = 16'h0010;
        step(LAT);
        complete_req_i = 1'b1;
        complete_id_i  = 5'd2;
        claim(5'd5);
        complete_req_i = 1'b0;
        chk("cc_after", 32'(pending_o), 32'h0);
        wsi_wires_i = 16'h0012;
        step(LAT);
        chk("cc_src1_idle", 32'(pending_o), 32'h0002);

        // Wire rise coinciding with a claim edge is not eligible.
        do_reset();
        wsi_wires_i = 16'h0001;
        step(LAT - 1);
        claim(5'd0);
        chk("rise_claim_pending", 32'(pending_o), 32'h0001);
        claim(5'd1);

        // Back-to-back claims.
        do_reset();
        wsi_wires_i = 16'h8003;
        step(LAT);
        wsi_wires_i = '0;
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd16);
        exp_q.push_back(5'd0);
        claim_req_i = 1'b1;
        step(4);
        claim_req_i = 1'b0;
        chk("b2b_pending", 32'(pending_o), 32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL claim_timeout observed_outstanding=%0d expected=0", exp_q.size());
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iommu_wsi_gateway.md
Name: iommu_wsi_gateway

Overview:
- Receiving end of the IOMMU wire-signaled interrupt (WSI) path. Samples the N_SRC level-sensitive WSI wires driven by the IOMMU interrupt generator.
- Holds one gateway state per wire. Arbitrates pending sources by fixed priority.
- Exposes a claim/complete handshake to the interrupt-handling agent (hart-side shim or test harness), giving exactly-once delivery per assertion episode.

Parameters:
- N_SRC, 16, number of WSI wires/sources (2..32).
- ID_W, $clog2(N_SRC)+1, claim/complete ID width; ID = source index + 1, ID 0 = "no source".

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wsi_wires_i  in  N_SRC  level WSI wires from the IOMMU
- enable_i  in  N_SRC  per-source enable mask
- claim_req_i  in  1  claim strobe, single cycle
- claim_valid_o  out  1  claim response pulse
- claim_id_o  out  ID_W  claimed ID (0 = nothing pending)
- complete_req_i  in  1  completion strobe
- complete_id_i  in  ID_W  ID being completed
- pending_o  out  N_SRC  per-source PENDING state
- irq_o  out  1  interrupt request to the hart

Behaviour:
- Reset (rst_i high at a clock edge): all sources IDLE; pending_o=0, irq_o=0, claim_valid_o=0, claim_id_o=0. Reset mid-handshake aborts it; no response pulse follows.
- Per-source FSM states: IDLE, PENDING, IN_SERVICE.
  - IDLE -> PENDING when the sampled wire is 1. The enable bit does not gate capture.
  - PENDING -> IN_SERVICE when selected by a claim.
  - IN_SERVICE -> IDLE on a complete whose complete_id_i equals this source's ID.
  - While IN_SERVICE, wire activity is ignored. No re-pend occurs until after completion.
- Level semantics: after completion, if the wire is still 1, the source re-enters PENDING on the next edge. Latency is 1 cycle IDLE->PENDING.
- Latency wire->pending_o: 1 cycle after wire=1 is present at an edge (without WSI_SYNC_EN).
- irq_o: registered. Equals OR over (next-state PENDING & enable_i), so it rises in the same cycle pending_o rises.
- Masked sources (enable=0) stay PENDING but are excluded from irq_o and from arbitration.
- Claim:
  - claim_req_i=1 at edge t selects the lowest-index source that is PENDING and enabled in the pre-edge state.
  - At t+1: claim_valid_o=1 for exactly one cycle, claim_id_o = index+1; that source is IN_SERVICE.
  - If none qualifies: claim_valid_o=1, claim_id_o=0, no state change.
  - claim_id_o holds its value until the next claim response.
- Back-to-back claims on consecutive cycles are legal. Each is evaluated against the state left by the previous one.
- Complete:
  - Acts only if the addressed source is IN_SERVICE.
  - ID 0, IDs > N_SRC, and non-IN_SERVICE IDs are ignored silently.
- Simultaneous claim + complete in the same cycle:
  - Both apply.
  - The completed source is not claim-eligible that cycle, because it is still IN_SERVICE pre-edge.
- Simultaneous wire rise + claim: a source becoming PENDING at the same edge is not eligible for that claim.

Optional Feature:
- Macro: IOMMU_WSI_SYNC_EN.
- Defined: wsi_wires_i passes through a 2-flop synchronizer per bit, reset to 0, before the FSM. Wire->pending_o latency becomes 3 cycles; irq_o tracks it.
- Undefined: wires are sampled directly and must be synchronous to clk_i. Latency is 1 cycle.

Test Plan:
- Reset: drive wires=16'hFFFF and pulse rst_i mid-claim -> cycle after reset: pending_o=0, irq_o=0, claim_valid_o=0. Capture resumes one cycle after rst_i drops.
- Priority: wires bits 3 and 9 high, enable=16'hFFFF, claim -> claim_id_o=4, pending_o=16'h0200. Second claim -> id 10, pending_o=0, irq_o=0.
- Masking: wire 5 high, enable[5]=0 -> pending_o[5]=1, irq_o=0, claim returns id 0. Set enable[5]=1 -> irq_o=1 next cycle, claim returns 6.
- Level re-pend: wire 0 held high, claim (id 1), complete id 1 -> pending_o[0]=1 one cycle later. Drop the wire before completing -> pending_o[0] stays 0.
- Illegal completes: complete id 0, id 17, and id 3 while source 2 is PENDING -> no state change on any source.
- Same-cycle claim + complete: source 1 IN_SERVICE, source 4 PENDING; claim together with complete id 2 -> claim_id_o=5, source 1 IDLE. With IOMMU_WSI_SYNC_EN, the wire rise appears on pending_o exactly 3 cycles later.
